// File: rtl/counter_nb_pkg.sv
// Shared mode encoding for the counter_nb block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package counter_nb_pkg;

    // MODO encoding, fully decoded by counter_nb_next
    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/counter_nb_next.sv
// Next-count datapath: computes q_next and the wrap flag from Q, MODO and D.
// Latency: purely combinational, no state.
// Backpressure: none; the caller gates with ENABLE. Saturation under COUNTER_NB_SAT_EN.
module counter_nb_next
    import counter_nb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_next,
    output logic             wrap
);

    localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    // One extra bit on every operation: the MSB is the carry (up/step) or borrow (down)
    logic [WIDTH:0] up_sum;
    logic [WIDTH:0] step_sum;
    logic [WIDTH:0] down_diff;

    assign up_sum    = {1'b0, q} + ONE_EXT;
    assign step_sum  = {1'b0, q} + STEP_EXT;
    assign down_diff = {1'b0, q} - ONE_EXT;

    // Mode decode: pick the result and flag the wrap (or saturation) event
    always_comb begin
        q_next = q;
        wrap   = 1'b0;
        case (modo)
            MODE_UP: begin
                q_next = up_sum[WIDTH-1:0];
                wrap   = up_sum[WIDTH];
`ifdef COUNTER_NB_SAT_EN
                if (up_sum[WIDTH]) q_next = '1;
`endif
            end
            MODE_DOWN: begin
                q_next = down_diff[WIDTH-1:0];
                wrap   = down_diff[WIDTH];
`ifdef COUNTER_NB_SAT_EN
                if (down_diff[WIDTH]) q_next = '0;
`endif
            end
            MODE_STEP: begin
                q_next = step_sum[WIDTH-1:0];
                wrap   = step_sum[WIDTH];
`ifdef COUNTER_NB_SAT_EN
                if (step_sum[WIDTH]) q_next = '1;
`endif
            end
            default: begin
                // MODE_LOAD: wrap stays low so RCO and LOAD never coincide
                q_next = d;
            end
        endcase
    end

endmodule

// File: rtl/counter_nb.sv
// Multi-mode counter (up/down/step/load) with registered RCO and LOAD strobes; COUNTER_NB_SAT_EN selects saturation.
// Latency: 1 cycle from sampled inputs to Q/RCO/LOAD; no combinational input-to-output path.
// Backpressure: none; ENABLE=0 holds Q and clears both strobes.
module counter_nb
    import counter_nb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             LOAD
);

    logic [WIDTH-1:0] q_next;
    logic             wrap;

    counter_nb_next #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next (
        .q      (Q),
        .modo   (MODO),
        .d      (D),
        .q_next (q_next),
        .wrap   (wrap)
    );

    // State registers: sync reset dominates, ENABLE gates the update, strobes are single-cycle
    always_ff @(posedge clk) begin
        if (!RESET) begin
            Q    <= '0;
            RCO  <= 1'b0;
            LOAD <= 1'b0;
        end else if (ENABLE) begin
            Q    <= q_next;
            RCO  <= wrap;
            LOAD <= (MODO == MODE_LOAD);
        end else begin
            RCO  <= 1'b0;
            LOAD <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_nb.sv
// Self-checking bench for counter_nb: vector table on a 4-bit/step-3 instance, sweep plus random on 8-bit/step-5.
// Latency: expectations are queued when stimulus is driven and compared 1 cycle later.
// Backpressure: n/a; expectations follow COUNTER_NB_SAT_EN when defined.
module tb_counter_nb;
    import counter_nb_pkg::*;

`ifdef COUNTER_NB_SAT_EN
    localparam int SAT = 1;
`else
    localparam int SAT = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, en4, rco4, ld4;
    logic [1:0] m4;
    logic [3:0] d4, q4;
    logic       rst8, en8, rco8, ld8;
    logic [1:0] m8;
    logic [7:0] d8, q8;

    counter_nb #(.WIDTH(4), .STEP(3)) dut4 (
        .clk(clk), .RESET(rst4), .ENABLE(en4), .MODO(m4), .D(d4),
        .Q(q4), .RCO(rco4), .LOAD(ld4)
    );

    counter_nb #(.WIDTH(8), .STEP(5)) dut8 (
        .clk(clk), .RESET(rst8), .ENABLE(en8), .MODO(m8), .D(d8),
        .Q(q8), .RCO(rco8), .LOAD(ld8)
    );

    typedef struct packed {
        logic [7:0] q;
        logic       rco;
        logic       ld;
    } out_t;

    typedef struct {
        int    rst;
        int    en;
        int    m;
        int    d;
        int    q;
        int    r;
        int    l;
        string nm;
    } vec_t;

    out_t  sb[$];
    string sbn[$];
    vec_t  tbl[$];
    int    checks = 0;
    int    errors = 0;

    function automatic out_t mk(input int q, input int r, input int l);
        out_t o;
        o.q   = 8'(q);
        o.rco = r[0];
        o.ld  = l[0];
        return o;
    endfunction

    // Reference model written from the behavioural description, integer arithmetic
    function automatic out_t ref_next(input int w, input int stp, input int q,
                                      input int rst, input int en, input int m, input int d);
        int   mx;
        int   s;
        out_t o;
        mx = (1 << w) - 1;
        o  = mk(q, 0, 0);
        if (rst == 0) begin
            o.q = 8'd0;
        end else if (en != 0) begin
            if (m == 0 || m == 2) begin
                s = q + ((m == 0) ? 1 : stp);
                if (s > mx) begin
                    o.rco = 1'b1;
                    o.q   = (SAT != 0) ? 8'(mx) : 8'(s - mx - 1);
                end else begin
                    o.q = 8'(s);
                end
            end else if (m == 1) begin
                if (q == 0) begin
                    o.rco = 1'b1;
                    o.q   = (SAT != 0) ? 8'd0 : 8'(mx);
                end else begin
                    o.q = 8'(q - 1);
                end
            end else begin
                o.q  = 8'(d);
                o.ld = 1'b1;
            end
        end
        return o;
    endfunction

    task automatic v(input int rst, input int en, input int m, input int d,
                     input int q, input int r, input int l, input string nm);
        vec_t t;
        t.rst = rst; t.en = en; t.m = m; t.d = d;
        t.q = q; t.r = r; t.l = l; t.nm = nm;
        tbl.push_back(t);
    endtask

    // Drive one DUT for one edge (the other holds), queue expectation, compare after the edge
    task automatic cyc(input int dut, input int rst, input int en, input int m, input int d,
                       input out_t e, input string nm);
        out_t  got;
        out_t  exp;
        string n;
        if (dut == 4) begin
            rst4 = rst[0]; en4 = en[0]; m4 = m[1:0]; d4 = d[3:0];
            rst8 = 1'b1;   en8 = 1'b0;
        end else begin
            rst8 = rst[0]; en8 = en[0]; m8 = m[1:0]; d8 = d[7:0];
            rst4 = 1'b1;   en4 = 1'b0;
        end
        sb.push_back(e);
        sbn.push_back(nm);
        @(posedge clk);
        #1;
        if (dut == 4) got = {4'b0000, q4, rco4, ld4};
        else          got = {q8, rco8, ld8};
        exp = sb.pop_front();
        n   = sbn.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got q=%0d rco=%0b load=%0b, expected q=%0d rco=%0b load=%0b",
                     n, got.q, got.rco, got.ld, exp.q, exp.rco, exp.ld);
        end
    endtask

    initial begin
        int   mq;
        int   rr, ee, mm, dd;
        out_t e;

        rst4 = 1'b1; en4 = 1'b0; m4 = 2'b00; d4 = 4'd0;
        rst8 = 1'b1; en8 = 1'b0; m8 = 2'b00; d8 = 8'd0;

        // 4-bit, STEP=3 vectors: rst, en, mode, d -> q, rco, load
        v(0, 0, 0, 0,   0, 0, 0, "reset_state");
        v(1, 1, 3, 9,   9, 0, 1, "load9");
        v(0, 1, 3, 5,   0, 0, 0, "reset_over_load");
        v(1, 1, 3, 15, 15, 0, 1, "load15");
        v(1, 1, 0, 0,  (SAT != 0) ? 15 : 0, 1, 0, "up_from_max");
        v(0, 1, 0, 0,   0, 0, 0, "reset_over_rco");
        v(1, 1, 3, 14, 14, 0, 1, "load14");
        v(1, 1, 0, 0,  15, 0, 0, "up_14");
        v(1, 1, 0, 0,  (SAT != 0) ? 15 : 0, 1, 0, "up_wrap");
        v(1, 1, 0, 0,  (SAT != 0) ? 15 : 1, SAT, 0, "up_after_wrap");
        v(1, 1, 3, 1,   1, 0, 1, "load1");
        v(1, 1, 1, 0,   0, 0, 0, "down_1");
        v(1, 1, 1, 0,  (SAT != 0) ? 0 : 15, 1, 0, "down_wrap");
        v(1, 1, 1, 0,  (SAT != 0) ? 0 : 14, SAT, 0, "down_after_wrap");
        v(1, 1, 3, 12, 12, 0, 1, "load12");
        v(1, 1, 2, 0,  15, 0, 0, "step_12");
        v(1, 1, 2, 0,  (SAT != 0) ? 15 : 2, 1, 0, "step_carry");
        v(1, 1, 2, 0,  (SAT != 0) ? 15 : 5, SAT, 0, "step_after_carry");
        v(1, 1, 3, 10, 10, 0, 1, "load10");
        for (int k = 0; k < 4; k++) v(1, 0, k, 7, 10, 0, 0, "hold");
        v(1, 1, 3, 3,   3, 0, 1, "load_b2b_a");
        v(1, 1, 3, 4,   4, 0, 1, "load_b2b_b");
        v(1, 1, 3, 15, 15, 0, 1, "load15_b");
        v(1, 1, 0, 0,  (SAT != 0) ? 15 : 0, 1, 0, "rco_before_load");
        v(1, 1, 3, 7,   7, 0, 1, "load_after_rco");
        v(1, 1, 1, 0,   6, 0, 0, "down_after_load");
        v(1, 0, 0, 0,   6, 0, 0, "hold_clears");

        foreach (tbl[i])
            cyc(4, tbl[i].rst, tbl[i].en, tbl[i].m, tbl[i].d,
                mk(tbl[i].q, tbl[i].r, tbl[i].l), tbl[i].nm);

        // 8-bit, STEP=5 hand sequence: carry out of the step adder
        cyc(8, 0, 0, 0, 0,   mk(0, 0, 0), "w8_reset");
        cyc(8, 1, 1, 3, 250, mk(250, 0, 1), "w8_load250");
        cyc(8, 1, 1, 2, 0,   mk(255, 0, 0), "w8_step_255");
        cyc(8, 1, 1, 2, 0,   mk((SAT != 0) ? 255 : 4, 1, 0), "w8_step_carry");
        cyc(8, 1, 1, 1, 0,   mk((SAT != 0) ? 254 : 3, 0, 0), "w8_mode_switch_down");

        // Random stream against the reference model, 8-bit instance
        cyc(8, 0, 1, 3, 9, mk(0, 0, 0), "w8_rand_reset");
        mq = 0;
        for (int i = 0; i < 10000; i++) begin
            rr = ($urandom_range(0, 63) == 0) ? 0 : 1;
            ee = ($urandom_range(0, 3) == 0) ? 0 : 1;
            mm = int'($urandom_range(0, 3));
            dd = int'($urandom_range(0, 255));
            e  = ref_next(8, 5, mq, rr, ee, mm, dd);
            mq = int'(e.q);
            cyc(8, rr, ee, mm, dd, e, "w8_random");
        end

        // Random stream against the reference model, 4-bit instance
        cyc(4, 0, 0, 0, 0, mk(0, 0, 0), "w4_rand_reset");
        mq = 0;
        for (int i = 0; i < 2000; i++) begin
            rr = ($urandom_range(0, 63) == 0) ? 0 : 1;
            ee = ($urandom_range(0, 3) == 0) ? 0 : 1;
            mm = int'($urandom_range(0, 3));
            dd = int'($urandom_range(0, 15));
            e  = ref_next(4, 3, mq, rr, ee, mm, dd);
            mq = int'(e.q);
            cyc(4, rr, ee, mm, dd, e, "w4_random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
